// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - writer side of the text character buffer
//
// Turns a byte stream into writes to the dual-port character RAM that the
// font renderer scans out. Tracks the cursor, interprets LF/CR/BS/FF and
// scrolls by advancing a ring-buffer row offset, so a scroll costs one line
// clear rather than a full buffer copy.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_in_valid       i_in_char is valid
//   o_in_ready       block can accept; transfer when valid & ready
//   i_in_char        character or control code
//   o_wr_en          char RAM write strobe
//   o_wr_addr        phys_row*COLS + col
//   o_wr_data        char code to write
//   o_cursor_x/y     logical cursor (row 0 = top of screen)
//   o_top_row        physical RAM row shown as screen row 0
//   o_busy           high while scrolling or clearing

module text_console_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 30,
    parameter logic [7:0] BLANK  = 8'h20,
    localparam int        ADDR_W = $clog2(COLS*ROWS),
    localparam int        CX_W   = $clog2(COLS),
    localparam int        CY_W   = $clog2(ROWS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [7:0]        i_in_char,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic [CX_W-1:0]   o_cursor_x,
    output logic [CY_W-1:0]   o_cursor_y,
    output logic [CY_W-1:0]   o_top_row,
    output logic              o_busy
);

    // Counter must reach COLS*ROWS itself (terminal value), hence the +1.
    localparam int                CNT_W  = $clog2(COLS*ROWS+1);
    localparam logic [CNT_W-1:0]  N_LINE = CNT_W'(COLS);
    localparam logic [CNT_W-1:0]  N_ALL  = CNT_W'(COLS*ROWS);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [CY_W:0]     ROWS_S = (CY_W+1)'(ROWS);

    // S_BOOT is the reset state: nothing is driven, and the first edge after
    // release issues clear address 0 and moves into S_CLEAR_ALL.
    typedef enum logic [2:0] {
        S_BOOT, S_IDLE, S_SCROLL, S_CLEAR_LINE, S_CLEAR_ALL
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CY_W-1:0]   r_clr_row;
    logic [CX_W-1:0]   r_cursor_x;
    logic [CY_W-1:0]   r_cursor_y;
    logic [CY_W-1:0]   r_top_row;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic              w_accept;
    logic              w_is_lf, w_is_cr, w_is_bs, w_is_ff, w_is_print;
    logic              w_last_col, w_last_row, w_newline, w_scroll;
    logic [CY_W:0]     w_row_sum;
    logic [CY_W-1:0]   w_phys_row;
    logic [CY_W-1:0]   w_top_inc;
    logic [ADDR_W-1:0] w_char_addr;
    logic [ADDR_W-1:0] w_line_addr;
    logic              w_line_pending, w_all_pending;

    assign w_accept   = i_in_valid && (r_state == S_IDLE);
    assign w_is_lf    = (i_in_char == 8'h0A);
    assign w_is_cr    = (i_in_char == 8'h0D);
    assign w_is_bs    = (i_in_char == 8'h08);
    assign w_is_ff    = (i_in_char == 8'h0C);
    assign w_is_print = !(w_is_lf || w_is_cr || w_is_bs || w_is_ff);
    assign w_last_col = (r_cursor_x == CX_W'(COLS-1));
    assign w_last_row = (r_cursor_y == CY_W'(ROWS-1));
    assign w_newline  = w_accept && (w_is_lf || (w_is_print && w_last_col));
    assign w_scroll   = w_newline && w_last_row;

    // Both operands are < ROWS, so one conditional subtract wraps the sum.
    assign w_row_sum  = {1'b0, r_top_row} + {1'b0, r_cursor_y};
    assign w_phys_row = (w_row_sum >= ROWS_S) ? CY_W'(w_row_sum - ROWS_S)
                                              : w_row_sum[CY_W-1:0];
    assign w_top_inc  = (r_top_row == CY_W'(ROWS-1)) ? '0 : r_top_row + 1'b1;

    assign w_char_addr    = ADDR_W'(w_phys_row) * COLS_A + ADDR_W'(r_cursor_x);
    assign w_line_addr    = ADDR_W'(r_clr_row) * COLS_A + ADDR_W'(r_cnt);
    assign w_line_pending = (r_cnt < N_LINE);
    assign w_all_pending  = (r_cnt < N_ALL);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_BOOT;
        else          r_state <= w_state_next;
    end

    // Next state. Clear states linger one cycle after their last write so the
    // renderer side sees in_ready rise only once that write has landed.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_BOOT:       w_state_next = S_CLEAR_ALL;
            S_IDLE: begin
                if (w_accept && w_is_ff) w_state_next = S_CLEAR_ALL;
                else if (w_scroll)       w_state_next = S_SCROLL;
            end
            S_SCROLL:     w_state_next = S_CLEAR_LINE;
            S_CLEAR_LINE: if (!w_line_pending) w_state_next = S_IDLE;
            S_CLEAR_ALL:  if (!w_all_pending)  w_state_next = S_IDLE;
            default:      w_state_next = S_BOOT;
        endcase
    end

    // Outputs
    always_comb begin
        o_in_ready = (r_state == S_IDLE);
        o_busy     = (r_state == S_SCROLL) || (r_state == S_CLEAR_LINE)
                  || (r_state == S_CLEAR_ALL);
    end

    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_cursor_x = r_cursor_x;
    assign o_cursor_y = r_cursor_y;
    assign o_top_row  = r_top_row;

    // Datapath: cursor, ring offset, clear counter and registered RAM port.
    // SCROLL already issues the first line-clear write so clears follow the
    // pending char write with no gap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_clr_row  <= '0;
            r_cursor_x <= '0;
            r_cursor_y <= '0;
            r_top_row  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_BOOT, S_CLEAR_ALL: begin
                    if (w_all_pending) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= ADDR_W'(r_cnt);
                        r_wr_data <= BLANK;
                        r_cnt     <= r_cnt + 1'b1;
                    end
                end
                S_SCROLL, S_CLEAR_LINE: begin
                    if (w_line_pending) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_line_addr;
                        r_wr_data <= BLANK;
                        r_cnt     <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_ff) begin
                            r_cursor_x <= '0;
                            r_cursor_y <= '0;
                            r_top_row  <= '0;
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= '0;
                            r_wr_data  <= BLANK;
                            r_cnt      <= CNT_W'(1);
                        end else if (w_is_lf || w_is_cr) begin
                            r_cursor_x <= '0;
                        end else if (w_is_bs) begin
                            if (r_cursor_x != '0) r_cursor_x <= r_cursor_x - 1'b1;
                        end else begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= w_char_addr;
                            r_wr_data  <= i_in_char;
                            r_cursor_x <= w_last_col ? '0 : r_cursor_x + 1'b1;
                        end
                    end
                    if (w_newline) begin
                        if (!w_last_row) begin
                            r_cursor_y <= r_cursor_y + 1'b1;
                        end else begin
                            r_top_row <= w_top_inc;
                            r_clr_row <= r_top_row;
                            r_cnt     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - scoreboard bench for text_console_writer
module tb_text_console_writer;

    localparam int         COLS  = 4;
    localparam int         ROWS  = 3;
    localparam logic [7:0] BLANK = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ready, wr_en, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] cx, cy, top;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];
    int m_x = 0, m_y = 0, m_top = 0;
    int cyc = 0, last_wr_cyc = 0, prev_wr_cyc = 0;
    int last_send_wait = 0;
    int n_low;

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_char(in_char), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_cursor_x(cx), .o_cursor_y(cy), .o_top_row(top), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [11:0] e;
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("extra_write", {24'd0, wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {28'd0, wr_addr}, {28'd0, e[11:8]});
                chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
            prev_wr_cyc <= last_wr_cyc;
            last_wr_cyc <= cyc;
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        exp_q.push_back({a[3:0], d});
    endtask

    task automatic m_newline();
        if (m_y < ROWS-1) begin
            m_y++;
        end else begin
            for (int i = 0; i < COLS; i++) push_wr(m_top*COLS + i, BLANK);
            m_top = (m_top + 1) % ROWS;
        end
    endtask

    task automatic model(input logic [7:0] c);
        case (c)
            8'h0A: begin m_x = 0; m_newline(); end
            8'h0D: m_x = 0;
            8'h08: if (m_x > 0) m_x--;
            8'h0C: begin
                m_x = 0; m_y = 0; m_top = 0;
                for (int i = 0; i < COLS*ROWS; i++) push_wr(i, BLANK);
            end
            default: begin
                push_wr(((m_top + m_y) % ROWS)*COLS + m_x, c);
                if (m_x == COLS-1) begin m_x = 0; m_newline(); end
                else m_x++;
            end
        endcase
    endtask

    // Called just after a posedge; returns just after the accepting posedge
    // with in_valid still high so sends can chain back to back.
    task automatic send(input logic [7:0] c);
        int k = 0;
        model(c);
        in_valid = 1'b1;
        in_char  = c;
        @(negedge clk);
        while (!in_ready && k < 200) begin k++; @(negedge clk); end
        last_send_wait = k;
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 200) begin step(1); n++; end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_x"},   {30'd0, cx},  m_x);
        chk({tag, "_y"},   {30'd0, cy},  m_y);
        chk({tag, "_top"}, {30'd0, top}, m_top);
    endtask

    task automatic chk_all_zero();
        chk("rst_wr_en",    {31'd0, wr_en},    0);
        chk("rst_wr_addr",  {28'd0, wr_addr},  0);
        chk("rst_wr_data",  {24'd0, wr_data},  0);
        chk("rst_cursor_x", {30'd0, cx},       0);
        chk("rst_cursor_y", {30'd0, cy},       0);
        chk("rst_top_row",  {30'd0, top},      0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_busy",     {31'd0, busy},     0);
    endtask

    // Releases reset just after a posedge and follows the power-up clear.
    task automatic boot_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_x = 0; m_y = 0; m_top = 0;
        for (int i = 0; i < COLS*ROWS; i++) push_wr(i, BLANK);
        chk("boot_idle_wr_en", {31'd0, wr_en}, 0);
        chk("boot_idle_ready", {31'd0, in_ready}, 0);
        for (int i = 0; i < COLS*ROWS; i++) begin
            step(1);
            chk("boot_wr_en", {31'd0, wr_en}, 1);
            chk("boot_ready_low", {31'd0, in_ready}, 0);
        end
        step(1);
        chk("boot_ready_rise", {31'd0, in_ready}, 1);
        chk("boot_wr_done", {31'd0, wr_en}, 0);
        chk("boot_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        // 1: reset state and power-up clear
        step(2);
        chk_all_zero();
        boot_check();

        // 2: back-to-back printable chars
        send("A");
        send("B");
        in_valid = 1'b0;
        chk("ab_no_stall", last_send_wait, 0);
        chk_cursor("ab");
        chk("ab_ready", {31'd0, in_ready}, 1);
        step(1);
        chk("ab_consecutive", last_wr_cyc - prev_wr_cyc, 1);

        // 3: wrap at end of row, then CR and BS at column 0
        send(8'h0C);
        in_valid = 1'b0;
        wait_ready(n_low);
        chk("ff_clear_len", n_low, COLS*ROWS);
        send("W"); send("X"); send("Y"); send("Z");
        in_valid = 1'b0;
        chk("wxyz_no_stall", last_send_wait, 0);
        chk_cursor("wxyz");
        chk("wxyz_ready", {31'd0, in_ready}, 1);
        send(8'h0D); send(8'h08);
        in_valid = 1'b0;
        chk_cursor("cr_bs");

        // 4: LF to bottom row, then LF scrolls
        send(8'h0A);
        in_valid = 1'b0;
        chk_cursor("lf_row2");
        send(8'h0A);
        in_valid = 1'b0;
        chk_cursor("lf_scroll");
        chk("scroll_busy", {31'd0, busy}, 1);
        wait_ready(n_low);
        chk("scroll_ready_low", n_low, 5);

        // 5: char lands on the physical row that became the bottom
        send("Q");
        in_valid = 1'b0;
        chk_cursor("q");

        // wrap on the last column of the last row also scrolls
        send("R"); send("S"); send("T");
        in_valid = 1'b0;
        chk_cursor("wrap_scroll");
        wait_ready(n_low);
        chk("wrap_ready_low", n_low, 5);
        chk("pre_ff_q_drained", exp_q.size(), 0);

        // 6: FF aborted by reset after the fifth clear write
        send(8'h0C);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_q_left", exp_q.size(), COLS*ROWS - 5);
        exp_q.delete();
        chk_all_zero();
        step(2);
        chk_all_zero();
        boot_check();
        chk_cursor("after_reset");

        step(3);
        chk("final_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
